// File: rtl/instruction_fetch_pkg.sv
// Shared MIPS definitions for the fetch/decode front end: opcodes, FSM encodings, NOP word.
package instruction_fetch_pkg;

    localparam logic [5:0] OPC_R    = 6'b000000;
    localparam logic [5:0] OPC_J    = 6'b000010;
    localparam logic [5:0] OPC_BEQ  = 6'b000100;
    localparam logic [5:0] OPC_ADDI = 6'b001000;
    localparam logic [5:0] OPC_LW   = 6'b100011;
    localparam logic [5:0] OPC_SW   = 6'b101011;
    localparam logic [5:0] OPC_HALT = 6'b111111;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[31:26];
    endfunction

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction store: one synchronous write port, one combinational read port.
module instruction_memory #(
    parameter int NB_ADDR = 8,
    parameter int NB_DATA = 32
) (
    input  logic               clk,
    input  logic               we,
    input  logic [NB_ADDR-1:0] waddr,
    input  logic [NB_DATA-1:0] wdata,
    input  logic [NB_ADDR-1:0] raddr,
    output logic [NB_DATA-1:0] rdata
);

    logic [NB_DATA-1:0] mem [0:(1<<NB_ADDR)-1];

    // Deliberately no reset: a loaded program survives i_rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch.sv
// MIPS IF stage: program counter, loadable instruction memory and the IF/ID register.
// IF/ID contract: o_valid qualifies o_pc/o_instruction; i_stall freezes them, i_redirect inserts one bubble.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int          NB_DATA     = 32,
    parameter int          NB_ADDR     = 8,
    parameter logic [5:0]  HALT_OPCODE = OPC_HALT
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_inst_we,
    input  logic [NB_ADDR-1:0] i_inst_waddr,
    input  logic [NB_DATA-1:0] i_inst_wdata,
    input  logic               i_stall,
    input  logic               i_redirect,
    input  logic [NB_DATA-1:0] i_target,
    output logic [NB_DATA-1:0] o_pc,
    output logic [NB_DATA-1:0] o_pc_plus4,
    output logic [NB_DATA-1:0] o_instruction,
    output logic               o_valid,
    output logic               o_halted,
    output logic [1:0]         o_state
);

    localparam logic [NB_DATA-1:0] PC_STEP = NB_DATA'(4);

    logic [1:0]         state;
    logic [NB_DATA-1:0] fetch_pc;
    logic [NB_DATA-1:0] fetch_word;
    logic [NB_DATA-1:0] if_id_pc;
    logic [NB_DATA-1:0] if_id_instr;
    logic               if_id_valid;
    logic               mem_we;
    logic               fetch_is_halt;

    // Writes complete in IDLE even when i_rst is asserted in the same cycle.
    assign mem_we = i_inst_we && (state == ST_IDLE);

    instruction_memory #(
        .NB_ADDR (NB_ADDR),
        .NB_DATA (NB_DATA)
    ) u_imem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (i_inst_waddr),
        .wdata (i_inst_wdata),
        .raddr (fetch_pc[NB_ADDR+1:2]),
        .rdata (fetch_word)
    );

    assign fetch_is_halt = (fetch_word[NB_DATA-1:NB_DATA-6] == HALT_OPCODE);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            fetch_pc    <= '0;
            if_id_pc    <= '0;
            if_id_instr <= NB_DATA'(NOP_WORD);
            if_id_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Stall outranks redirect; ID keeps the redirect asserted until the stall drops.
                    if (i_stall) begin
                        fetch_pc <= fetch_pc;
                    end else if (i_redirect) begin
                        fetch_pc    <= {i_target[NB_DATA-1:2], 2'b00};
                        if_id_pc    <= '0;
                        if_id_instr <= NB_DATA'(NOP_WORD);
                        if_id_valid <= 1'b0;
                    end else begin
                        if_id_pc    <= fetch_pc;
                        if_id_instr <= fetch_word;
                        if_id_valid <= 1'b1;
                        if (fetch_is_halt) begin
                            state <= ST_HALTED;
                        end else begin
                            fetch_pc <= fetch_pc + PC_STEP;
                        end
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    assign o_pc          = if_id_pc;
    assign o_pc_plus4    = if_id_pc + PC_STEP;
    assign o_instruction = if_id_instr;
    assign o_valid       = if_id_valid;
    assign o_halted      = (state == ST_HALTED);
    assign o_state       = state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with hand-computed expectations.
module tb_instruction_fetch;

    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 8;

    logic               clk = 1'b0;
    logic               i_rst = 1'b0;
    logic               i_start = 1'b0;
    logic               i_inst_we = 1'b0;
    logic [NB_ADDR-1:0] i_inst_waddr = '0;
    logic [NB_DATA-1:0] i_inst_wdata = '0;
    logic               i_stall = 1'b0;
    logic               i_redirect = 1'b0;
    logic [NB_DATA-1:0] i_target = '0;
    logic [NB_DATA-1:0] o_pc;
    logic [NB_DATA-1:0] o_pc_plus4;
    logic [NB_DATA-1:0] o_instruction;
    logic               o_valid;
    logic               o_halted;
    logic [1:0]         o_state;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_inst_we     (i_inst_we),
        .i_inst_waddr  (i_inst_waddr),
        .i_inst_wdata  (i_inst_wdata),
        .i_stall       (i_stall),
        .i_redirect    (i_redirect),
        .i_target      (i_target),
        .o_pc          (o_pc),
        .o_pc_plus4    (o_pc_plus4),
        .o_instruction (o_instruction),
        .o_valid       (o_valid),
        .o_halted      (o_halted),
        .o_state       (o_state)
    );

    always #5 clk = ~clk;

    // Clock edge then settle, so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                              input logic valid);
        check_eq({tag, ".pc"}, o_pc, pc);
        check_eq({tag, ".pc4"}, o_pc_plus4, pc + 32'd4);
        check_eq({tag, ".instr"}, o_instruction, instr);
        check_eq({tag, ".valid"}, {31'd0, o_valid}, {31'd0, valid});
    endtask

    task automatic check_reset_outputs(input string tag);
        check_ifid(tag, 32'h0, 32'h0, 1'b0);
        check_eq({tag, ".halted"}, {31'd0, o_halted}, 32'd0);
        check_eq({tag, ".state"}, {30'd0, o_state}, 32'd0);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
    endtask

    task automatic load_word(input int addr, input logic [31:0] data);
        i_inst_we    = 1'b1;
        i_inst_waddr = NB_ADDR'(addr);
        i_inst_wdata = data;
        tick();
        i_inst_we    = 1'b0;
    endtask

    task automatic start_run();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    function automatic logic [31:0] prog_word(input int i);
        return 32'h2000_0100 + 32'(i);
    endfunction

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick();
        do_reset();
        check_reset_outputs("reset");

        // Load and run to HALT
        load_word(0, 32'h2001_0005);
        load_word(1, 32'h2002_0007);
        load_word(2, 32'hFC00_0000);
        start_run();
        check_eq("start.state", {30'd0, o_state}, 32'd1);
        check_eq("start.valid", {31'd0, o_valid}, 32'd0);
        tick();
        check_ifid("run0", 32'h0, 32'h2001_0005, 1'b1);
        tick();
        check_ifid("run1", 32'h4, 32'h2002_0007, 1'b1);
        check_eq("run1.halted", {31'd0, o_halted}, 32'd0);
        tick();
        check_ifid("halt", 32'h8, 32'hFC00_0000, 1'b1);
        check_eq("halt.halted", {31'd0, o_halted}, 32'd1);
        check_eq("halt.state", {30'd0, o_state}, 32'd2);
        i_stall = 1'b0;
        i_redirect = 1'b1;
        i_target = 32'h40;
        i_start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_ifid("halt_hold", 32'h8, 32'hFC00_0000, 1'b1);
            check_eq("halt_hold.state", {30'd0, o_state}, 32'd2);
        end
        i_redirect = 1'b0;
        i_start = 1'b0;

        // Stall: IF/ID frozen at pc 4 for three cycles
        do_reset();
        check_reset_outputs("reset2");
        for (int i = 0; i < 12; i++) load_word(i, prog_word(i));
        start_run();
        tick();
        check_ifid("s_pc0", 32'h0, prog_word(0), 1'b1);
        tick();
        check_ifid("s_pc4", 32'h4, prog_word(1), 1'b1);
        i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_ifid("stall_hold", 32'h4, prog_word(1), 1'b1);
        end
        i_stall = 1'b0;
        tick();
        check_ifid("s_pc8", 32'h8, prog_word(2), 1'b1);
        tick();
        check_ifid("s_pcC", 32'hC, prog_word(3), 1'b1);

        // Redirect with fetch_pc = 8; target low bits are dropped
        do_reset();
        start_run();
        tick();
        tick();
        check_ifid("r_pc4", 32'h4, prog_word(1), 1'b1);
        i_redirect = 1'b1;
        i_target = 32'h13;
        tick();
        check_ifid("r_bubble", 32'h0, 32'h0, 1'b0);
        i_redirect = 1'b0;
        tick();
        check_ifid("r_target", 32'h10, prog_word(4), 1'b1);

        // Stall and redirect together: redirect waits for the stall to drop
        i_stall = 1'b1;
        i_redirect = 1'b1;
        i_target = 32'h4;
        tick();
        check_ifid("sr_hold", 32'h10, prog_word(4), 1'b1);
        i_stall = 1'b0;
        tick();
        check_ifid("sr_bubble", 32'h0, 32'h0, 1'b0);
        i_redirect = 1'b0;
        tick();
        check_ifid("sr_target", 32'h4, prog_word(1), 1'b1);

        // i_start during RUN has no effect
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check_eq("start_in_run.state", {30'd0, o_state}, 32'd1);
        check_ifid("start_in_run", 32'h8, prog_word(2), 1'b1);

        // Run to pc 0x20 then reset mid-RUN
        for (int k = 0; k < 6; k++) tick();
        check_ifid("pre_rst", 32'h20, prog_word(8), 1'b1);
        i_stall = 1'b1;
        i_redirect = 1'b1;
        do_reset();
        i_stall = 1'b0;
        i_redirect = 1'b0;
        check_reset_outputs("rst_mid_run");

        // Writes during RUN are ignored
        start_run();
        i_inst_we = 1'b1;
        i_inst_waddr = 8'd1;
        i_inst_wdata = 32'hDEAD_BEEF;
        tick();
        i_inst_we = 1'b0;
        check_ifid("gate_pc0", 32'h0, prog_word(0), 1'b1);
        do_reset();
        start_run();
        tick();
        tick();
        check_ifid("gate_pc4", 32'h4, prog_word(1), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

MIPS pipeline IF stage, directly upstream of instruction decode and the opcode/funct control decoder. Holds the program counter, a loadable word-addressed instruction memory, and the IF/ID pipeline register. Applies stall and redirect (jump/branch) requests from ID and stops fetching on a HALT opcode. The decoder reads instruction fields only from this block's registered outputs.

## Interface
- NB_DATA, 32, instruction and PC width
- NB_ADDR, 8, instruction memory depth is 2^NB_ADDR words
- HALT_OPCODE, 6'b111111, opcode in [31:26] that stops fetch
- clk  in  1  single clock; all state updates on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  one-cycle pulse; IDLE -> RUN
- i_inst_we  in  1  program-load write enable; honoured only in IDLE
- i_inst_waddr  in  NB_ADDR  program-load word address
- i_inst_wdata  in  NB_DATA  program-load instruction word
- i_stall  in  1  hold PC and IF/ID register (load-use hazard from ID)
- i_redirect  in  1  take i_target this cycle (taken branch or jump resolved in ID)
- i_target  in  NB_DATA  byte address of redirect target
- o_pc  out  NB_DATA  PC of the instruction in IF/ID
- o_pc_plus4  out  NB_DATA  o_pc + 4
- o_instruction  out  NB_DATA  IF/ID instruction; 0 (NOP) when invalid
- o_valid  out  1  IF/ID holds a real instruction
- o_halted  out  1  HALT fetched; fetch stopped
- o_state  out  2  FSM state, for debug

## Operation
- FSM states: IDLE=0, RUN=1, HALTED=2. Transitions:
  - IDLE -> RUN on i_start.
  - RUN -> HALTED when an unstalled fetch reads an opcode equal to HALT_OPCODE.
  - HALTED is left only by i_rst.
- Memory: 2^NB_ADDR x NB_DATA array, combinational read. Index is pc[NB_ADDR+1:2]; higher PC bits alias. Contents are not cleared by reset.
- Program load: in IDLE, i_inst_we writes i_inst_wdata to i_inst_waddr on the next edge. In RUN and HALTED, i_inst_we is ignored.
- PC (fetch_pc) next-value priority, evaluated in RUN only:
  1. i_stall: hold fetch_pc and IF/ID. A concurrent i_redirect is ignored; ID must hold it until the stall drops.
  2. i_redirect: fetch_pc <= {i_target[NB_DATA-1:2], 2'b00} (low bits forced to 0). IF/ID <= bubble (instruction 0, valid 0, pc 0).
  3. Otherwise: IF/ID <= {mem[fetch_pc], fetch_pc, valid 1}; fetch_pc <= fetch_pc + 4, wrapping modulo 2^NB_DATA.
- HALT fetch: the HALT word is still loaded into IF/ID with valid 1, so downstream sees it. fetch_pc does not advance past it.
- In HALTED and IDLE: fetch_pc and IF/ID hold; stall and redirect are ignored.
- o_pc_plus4 is computed from the registered o_pc. It is combinational and not separately registered.

## Timing
- Reset (i_rst high at an edge): fetch_pc=0, o_pc=0, o_pc_plus4=4, o_instruction=0, o_valid=0, o_halted=0, o_state=IDLE.
- i_rst mid-RUN or mid-load: reset wins over every other input in that cycle. Any in-flight write still completes only if i_inst_we is high and the state was IDLE.
- i_start pulse at edge N: first fetch happens at edge N+1; o_valid=1 after edge N+1 with o_pc=0.
- Steady RUN with no stall: one instruction per cycle; IF/ID latency is 1 cycle from fetch_pc.
- Redirect at edge N: exactly one bubble after edge N; target instruction appears in IF/ID after edge N+1.
- Stall held k cycles: IF/ID outputs stay constant for k cycles and resume on the first unstalled edge.
- o_halted rises at the same edge that loads the HALT word into IF/ID.
- i_start while already in RUN or HALTED: no effect.

## Structure
- Shared MIPS package holds:
  - opcode constants (HALT_OPCODE, R/LW/SW/BEQ/ADDI/J)
  - FSM state encodings IDLE/RUN/HALTED
  - NOP word = 32'h0000_0000
- Sub-module instruction_memory: write port plus combinational read port, parameterised by NB_ADDR and NB_DATA.
- PC register, FSM and IF/ID register live in instruction_fetch.

## Test plan
- Load and run: write 0x20010005, 0x20020007, 0xFC000000 at words 0..2; pulse i_start. Required IF/ID sequence: (pc 0, 0x20010005), (pc 4, 0x20020007), (pc 8, 0xFC000000) with o_halted=1. Then hold 10 cycles: outputs and o_state=2 unchanged.
- Stall: assert i_stall for 3 cycles while IF/ID holds pc 4. Required: o_pc=4 and the same instruction for 3 cycles; pc 8 arrives on the first free edge; no instruction skipped or duplicated.
- Redirect: i_redirect with i_target=0x13 while fetch_pc=8. Required: one bubble (o_valid=0, o_instruction=0), then o_pc=0x10 with mem[4].
- Stall plus redirect in the same cycle: redirect ignored, state held. The redirect is honoured on the first edge where it stays asserted without stall.
- Load gating: i_inst_we=1 during RUN to word 1. Required: mem[1] unchanged after a reset and re-run.
- Reset mid-RUN at pc 0x20: all outputs take their reset values on the next edge; o_state=IDLE; memory contents retained.
